// File: rtl/step_sequencer.sv
// Step sequencer: walks 16 pattern steps at a programmable tempo, presenting pitch, gate and step ticks.
// Define LIVE_EDIT_EN to re-sample the current step's pitch every cycle instead of only at step start.
module step_sequencer #(
    parameter int CLK_HZ      = 12000000,
    parameter int BPM_DEFAULT = 120,
    parameter int BPM_MIN     = 30,
    parameter int DIV_W       = 28,
    parameter int PERIOD_W    = 24,
    parameter int GATE_SHIFT  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [47:0] beats,
    input  logic        run,
    input  logic [7:0]  tempo_bpm,
    input  logic        tempo_load,
    output logic [3:0]  step_idx,
    output logic [2:0]  pitch,
    output logic        gate,
    output logic        step_tick,
    output logic        busy
);

    localparam int CNT_W = $clog2(DIV_W);
    localparam longint PMAX  = (longint'(1) << PERIOD_W) - 1;
    localparam longint DEF_Q = longint'(CLK_HZ) * 15 / BPM_DEFAULT;
    localparam logic [PERIOD_W-1:0] PERIOD_RST   = PERIOD_W'((DEF_Q > PMAX) ? PMAX : DEF_Q);
    localparam logic [DIV_W-1:0]    PERIOD_MAX_D = DIV_W'(PMAX);
    localparam logic [DIV_W-1:0]    DIVIDEND     = DIV_W'(longint'(CLK_HZ) * 15);
    localparam logic [7:0]          BPM_MIN_C    = 8'(BPM_MIN);

    typedef enum logic {ST_STOP, ST_PLAY} state_t;

    function automatic logic [PERIOD_W-1:0] sat_period(input logic [DIV_W-1:0] q);
        if (q > PERIOD_MAX_D)
            return '1;
        return q[PERIOD_W-1:0];
    endfunction

    function automatic logic [2:0] step_pitch(input logic [47:0] b, input logic [3:0] k);
        int base;
        base = int'(k) * 3;
        return b[base +: 3];
    endfunction

    state_t              state;
    logic [PERIOD_W-1:0] phase;
    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] pending_period;
    logic [CNT_W-1:0]    div_cnt;
    logic [7:0]          bpm_c;
    logic [7:0]          rem;
    logic [DIV_W-1:0]    dq;

    logic [8:0]          rem_shift;
    logic [8:0]          rem_sub;
    logic                rem_ge;
    logic [DIV_W-1:0]    quot_next;
    logic                div_done;
    logic [PERIOD_W-1:0] pending_eff;
    logic [PERIOD_W:0]   phase_inc;
    logic                boundary;
    logic                win_next;
    logic [3:0]          idx_inc;
    logic [2:0]          pitch_new;
    logic [2:0]          pitch_hold;

    always_comb begin
        rem_shift  = {rem, dq[DIV_W-1]};
        rem_ge     = rem_shift >= {1'b0, bpm_c};
        rem_sub    = rem_shift - {1'b0, bpm_c};
        quot_next  = {dq[DIV_W-2:0], rem_ge};
        div_done   = busy && (div_cnt == CNT_W'(DIV_W - 1));
        // A quotient finishing on a boundary cycle is forwarded straight to the starting step.
        pending_eff = div_done ? sat_period(quot_next) : pending_period;
        phase_inc  = {1'b0, phase} + (PERIOD_W+1)'(1);
        boundary   = phase_inc >= {1'b0, period};
        win_next   = (period < PERIOD_W'(2)) || (phase_inc < {1'b0, period >> GATE_SHIFT});
        idx_inc    = step_idx + 4'd1;
        pitch_new  = step_pitch(beats, idx_inc);
`ifdef LIVE_EDIT_EN
        pitch_hold = step_pitch(beats, step_idx);
`else
        pitch_hold = pitch;
`endif
    end

    // Restoring divider datapath: one quotient bit per busy cycle, quotient shifts into dq.
    always_ff @(posedge clk) begin
        if (!busy && tempo_load) begin
            bpm_c <= (tempo_bpm < BPM_MIN_C) ? BPM_MIN_C : tempo_bpm;
            dq    <= DIVIDEND;
            rem   <= 8'd0;
        end else if (busy) begin
            rem <= rem_ge ? rem_sub[7:0] : rem_shift[7:0];
            dq  <= quot_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_STOP;
            phase          <= '0;
            step_idx       <= 4'd0;
            pitch          <= 3'd0;
            gate           <= 1'b0;
            step_tick      <= 1'b0;
            period         <= PERIOD_RST;
            pending_period <= PERIOD_RST;
            busy           <= 1'b0;
            div_cnt        <= '0;
        end else begin
            if (busy) begin
                div_cnt <= div_cnt + CNT_W'(1);
                if (div_done) begin
                    busy           <= 1'b0;
                    pending_period <= pending_eff;
                end
            end else if (tempo_load) begin
                busy    <= 1'b1;
                div_cnt <= '0;
            end

            case (state)
                ST_STOP: begin
                    period    <= pending_eff;
                    gate      <= 1'b0;
                    step_tick <= 1'b0;
                    if (run) begin
                        state     <= ST_PLAY;
                        phase     <= '0;
                        step_idx  <= 4'd0;
                        pitch     <= beats[2:0];
                        gate      <= beats[2:0] != 3'd0;
                        step_tick <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (!run) begin
                        state     <= ST_STOP;
                        gate      <= 1'b0;
                        step_tick <= 1'b0;
                    end else if (boundary) begin
                        phase     <= '0;
                        step_idx  <= idx_inc;
                        pitch     <= pitch_new;
                        gate      <= pitch_new != 3'd0;
                        step_tick <= 1'b1;
                        period    <= pending_eff;
                    end else begin
                        phase     <= phase_inc[PERIOD_W-1:0];
                        pitch     <= pitch_hold;
                        gate      <= win_next && (pitch_hold != 3'd0);
                        step_tick <= 1'b0;
                    end
                end
                default: state <= ST_STOP;
            endcase
        end
    end

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: directed tempo/step scenarios plus random stimulus against a behavioural model.
module tb_step_sequencer;
    localparam int CLK_HZ = 1600;
    localparam int BPMD   = 120;
    localparam int DIV_W  = 28;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [47:0] beats = '0;
    logic        run = 1'b0;
    logic [7:0]  tempo_bpm = 8'd0;
    logic        tempo_load = 1'b0;
    logic [3:0]  step_idx;
    logic [2:0]  pitch;
    logic        gate;
    logic        step_tick;
    logic        busy;

    always #5 clk = ~clk;

    step_sequencer #(
        .CLK_HZ(CLK_HZ), .BPM_DEFAULT(BPMD), .BPM_MIN(30),
        .DIV_W(DIV_W), .PERIOD_W(24), .GATE_SHIFT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .beats(beats), .run(run),
        .tempo_bpm(tempo_bpm), .tempo_load(tempo_load),
        .step_idx(step_idx), .pitch(pitch), .gate(gate),
        .step_tick(step_tick), .busy(busy)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int tempo_period(input int bpm);
        int b, q;
        b = (bpm < 30) ? 30 : bpm;
        q = CLK_HZ * 15 / b;
        if (q > (1 << 24) - 1) q = (1 << 24) - 1;
        return q;
    endfunction

    function automatic int beat_at(input logic [47:0] b, input int k);
        logic [47:0] t;
        t = b >> (3 * k);
        return int'(t[2:0]);
    endfunction

    // Behavioural model: which step, how far into it, and what tempo is pending.
    bit m_play, m_gate, m_tick;
    int m_idx, m_pos, m_per, m_pend, m_div_left, m_div_res, m_pitch;

    initial begin
        int eff;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_play = 0; m_idx = 0; m_pos = 0; m_pitch = 0; m_gate = 0; m_tick = 0;
                m_per = tempo_period(BPMD); m_pend = m_per; m_div_left = 0;
            end else begin
                eff = (m_div_left == 1) ? m_div_res : m_pend;
                if (m_div_left > 0) begin
                    m_div_left--;
                    if (m_div_left == 0) m_pend = m_div_res;
                end else if (tempo_load) begin
                    m_div_left = DIV_W;
                    m_div_res  = tempo_period(int'(tempo_bpm));
                end
                if (!m_play) begin
                    m_per = eff; m_tick = 0; m_gate = 0;
                    if (run) begin
                        m_play = 1; m_idx = 0; m_pos = 0; m_tick = 1;
                        m_pitch = beat_at(beats, 0);
                        m_gate = (m_pitch != 0);
                    end
                end else if (!run) begin
                    m_play = 0; m_gate = 0; m_tick = 0;
                end else if (m_pos + 1 >= m_per) begin
                    m_per = eff; m_idx = (m_idx + 1) % 16; m_pos = 0; m_tick = 1;
                    m_pitch = beat_at(beats, m_idx);
                    m_gate = (m_pitch != 0);
                end else begin
                    m_pos++; m_tick = 0;
`ifdef LIVE_EDIT_EN
                    m_pitch = beat_at(beats, m_idx);
`endif
                    m_gate = (m_pitch != 0) && (m_per < 2 || m_pos < m_per / 2);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("step_idx", step_idx, m_idx);
            chk("pitch", pitch, m_pitch);
            chk("gate", gate, m_gate);
            chk("step_tick", step_tick, m_tick);
            chk("busy", busy, (m_div_left > 0));
        end
    end

    // Event recorder for the literal timing checks.
    int cyc = 0;
    int tick_q[$], idx_q[$], pitch_q[$], gate_q[$], busy_q[$];
    int gcnt = 0, brun = 0;
    bit g_started = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (step_tick === 1'b1) begin
                tick_q.push_back(cyc);
                idx_q.push_back(int'(step_idx));
                pitch_q.push_back(int'(pitch));
                if (g_started) gate_q.push_back(gcnt);
                gcnt = int'(gate);
                g_started = 1;
            end else begin
                gcnt += int'(gate);
            end
            if (busy === 1'b1) brun++;
            else if (brun > 0) begin
                busy_q.push_back(brun);
                brun = 0;
            end
        end
    end

    task automatic clear_q();
        tick_q.delete(); idx_q.delete(); pitch_q.delete(); gate_q.delete(); busy_q.delete();
        g_started = 0; gcnt = 0;
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic wait_ticks(input int n, input int limit);
        int c;
        c = 0;
        while (tick_q.size() < n && c < limit) begin
            @(posedge clk);
            #2;
            c++;
        end
        chk("tick_wait", tick_q.size(), n);
    endtask

    initial begin
        for (int k = 0; k < 16; k++)
            beats[3*k +: 3] = (k == 0) ? 3'd5 : (k == 1) ? 3'd0 : 3'((k % 7) + 1);

        repeat (3) @(negedge clk);
        chk("rst_step_idx", step_idx, 0);
        chk("rst_gate", gate, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_tick", step_tick, 0);

        // Basic playback at 200-cycle steps.
        clear_q();
        run = 1'b1;
        wait_ticks(3, 1000);
        chk("step_len0", qget(tick_q, 1) - qget(tick_q, 0), 200);
        chk("step_len1", qget(tick_q, 2) - qget(tick_q, 1), 200);
        chk("gate_len_note", qget(gate_q, 0), 100);
        chk("gate_len_rest", qget(gate_q, 1), 0);
        chk("first_pitch", qget(pitch_q, 0), 5);
        chk("rest_pitch", qget(pitch_q, 1), 0);

        wait_ticks(17, 4000);
        chk("idx_15", qget(idx_q, 15), 15);
        chk("idx_wrap", qget(idx_q, 16), 0);
        chk("wrap_pitch", qget(pitch_q, 16), 5);

        // Tempo change mid-step, plus a load that must be ignored while busy.
        clear_q();
        wait_ticks(1, 400);
        repeat (50) @(negedge clk);
        tempo_bpm = 8'd60; tempo_load = 1'b1;
        @(negedge clk) tempo_load = 1'b0;
        repeat (10) @(negedge clk);
        tempo_bpm = 8'd200; tempo_load = 1'b1;
        @(negedge clk) tempo_load = 1'b0;
        wait_ticks(3, 1000);
        chk("old_period_kept", qget(tick_q, 1) - qget(tick_q, 0), 200);
        chk("bpm60_period", qget(tick_q, 2) - qget(tick_q, 1), 400);
        chk("busy_count", busy_q.size(), 1);
        chk("busy_len", qget(busy_q, 0), 28);
        @(negedge clk);
        tempo_bpm = 8'd10; tempo_load = 1'b1;
        @(negedge clk) tempo_load = 1'b0;
        wait_ticks(5, 2000);
        chk("bpm60_again", qget(tick_q, 3) - qget(tick_q, 2), 400);
        chk("bpm_clamped", qget(tick_q, 4) - qget(tick_q, 3), 800);
        chk("busy_len2", qget(busy_q, 1), 28);

        // Tempo load while stopped applies at once; stop at step 5 and restart.
        @(negedge clk);
        run = 1'b0; tempo_bpm = 8'd120; tempo_load = 1'b1;
        @(negedge clk) tempo_load = 1'b0;
        repeat (40) @(negedge clk);
        clear_q();
        run = 1'b1;
        wait_ticks(6, 2000);
        chk("stopped_load", qget(tick_q, 1) - qget(tick_q, 0), 200);
        chk("idx_5", qget(idx_q, 5), 5);
        @(negedge clk) run = 1'b0;
        repeat (2) @(negedge clk);
        chk("stop_gate", gate, 0);
        chk("stop_idx", step_idx, 5);
        chk("stop_pitch", pitch, 6);
        chk("stop_tick", step_tick, 0);
        clear_q();
        run = 1'b1;
        wait_ticks(1, 10);
        chk("restart_idx", qget(idx_q, 0), 0);
        chk("restart_pitch", qget(pitch_q, 0), 5);

        // Edit a resting step0 into a note mid-window.
        @(negedge clk) run = 1'b0;
        beats[2:0] = 3'd0;
        @(negedge clk);
        clear_q();
        run = 1'b1;
        wait_ticks(1, 10);
        chk("edit_rest_pitch", qget(pitch_q, 0), 0);
        repeat (20) @(negedge clk);
        beats[2:0] = 3'b011;
        @(negedge clk);
`ifdef LIVE_EDIT_EN
        chk("edit_gate", gate, 1);
        chk("edit_pitch", pitch, 3);
`else
        chk("edit_gate", gate, 0);
        chk("edit_pitch", pitch, 0);
`endif

        // Asynchronous reset in the middle of a cycle while playing.
        repeat (37) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_idx", step_idx, 0);
        chk("async_rst_pitch", pitch, 0);
        chk("async_rst_gate", gate, 0);
        chk("async_rst_busy", busy, 0);
        run = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_tick", step_tick, 0);
        chk("post_rst_idx", step_idx, 0);

        // Random phase, checked cycle by cycle against the model.
        run = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            int r;
            @(negedge clk);
            r = $urandom_range(0, 999);
            tempo_load = 1'b0;
            if (r < 3) run = ~run;
            if (r >= 10 && r < 14) begin
                tempo_bpm  = 8'($urandom_range(0, 255));
                tempo_load = 1'b1;
            end
            if (r >= 100 && r < 130)
                beats[3*$urandom_range(0, 15) +: 3] = 3'($urandom_range(0, 7));
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 3999) == 0) rst_n = 1'b0;
        end
        tempo_load = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
